ti_sbox_sequencer: RTL and testbench



---
 rtl/ti_sbox_sequencer.sv | 118 +++++++++++
 tb/tb_ti_sbox_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ti_sbox_sequencer.sv
// Serial sequencer that streams a three-share NIB-nibble state through one shared
// two-stage threshold-implementation S-box and collects the substituted result.
module ti_sbox_sequencer #(
    parameter int NIB = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4*NIB-1:0] din_a,
    input  logic [4*NIB-1:0] din_b,
    input  logic [4*NIB-1:0] din_c,
    output logic [11:0]      s1_in,
    input  logic [11:0]      s1_out,
    output logic [11:0]      s2_in,
    input  logic [11:0]      s2_out,
    output logic [4*NIB-1:0] dout_a,
    output logic [4*NIB-1:0] dout_b,
    output logic [4*NIB-1:0] dout_c,
    output logic             busy,
    output logic             done
);

    localparam int W  = 4 * NIB;
    localparam int CW = $clog2(NIB + 1);
    localparam logic [CW-1:0] NIB_CNT = CW'(NIB);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   sh_a, sh_b, sh_c;
    logic [W-1:0]   res_a, res_b, res_c;
    logic [W-1:0]   ins_a, ins_b, ins_c;
    logic [11:0]    st1, st2;
    logic           v1, v2;
    logic           done_r;
    logic           issuing, load, last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // The pipeline has drained when stage 2 holds the final nibble and stage 1 is empty.
    always_comb begin
        state_nx = state;
        issuing  = 1'b0;
        load     = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                issuing = (cnt < NIB_CNT);
                last    = v2 && !v1;
                if (last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign ins_a = W'(st2[3:0])  << (W - 4);
    assign ins_b = W'(st2[7:4])  << (W - 4);
    assign ins_c = W'(st2[11:8]) << (W - 4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            sh_a   <= '0;
            sh_b   <= '0;
            sh_c   <= '0;
            st1    <= '0;
            st2    <= '0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            res_a  <= '0;
            res_b  <= '0;
            res_c  <= '0;
            done_r <= 1'b0;
        end else begin
            if (load) begin
                sh_a <= din_a;
                sh_b <= din_b;
                sh_c <= din_c;
                cnt  <= '0;
            end else if (issuing) begin
                sh_a <= sh_a >> 4;
                sh_b <= sh_b >> 4;
                sh_c <= sh_c >> 4;
                cnt  <= cnt + CW'(1);
            end
            // Stage registers are the glitch barrier between the two TI stages.
            st1 <= s1_out;
            v1  <= issuing;
            st2 <= s2_out;
            v2  <= v1;
            if (v2) begin
                res_a <= (res_a >> 4) | ins_a;
                res_b <= (res_b >> 4) | ins_b;
                res_c <= (res_c >> 4) | ins_c;
            end
            done_r <= last;
        end
    end

    assign s1_in  = issuing ? {sh_c[3:0], sh_b[3:0], sh_a[3:0]} : 12'h000;
    assign s2_in  = st1;
    assign dout_a = res_a;
    assign dout_b = res_b;
    assign dout_c = res_c;
    assign busy   = (state == RUN);
    assign done   = done_r;

endmodule

// File: tb/tb_ti_sbox_sequencer.sv
// Self-checking bench for ti_sbox_sequencer: a NIB=16 instance with selectable S-box stubs
// and a NIB=1 instance with identity stubs, checked against a nibble-wise reference model.
module tb_ti_sbox_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start16 = 1'b0;
    logic [63:0] din_a16 = '0, din_b16 = '0, din_c16 = '0;
    logic [11:0] s1i16, s1o16, s2i16, s2o16;
    logic [63:0] dout_a16, dout_b16, dout_c16;
    logic        busy16, done16;

    logic        start1 = 1'b0;
    logic [3:0]  din_a1 = '0, din_b1 = '0, din_c1 = '0;
    logic [11:0] s1i1, s2i1;
    logic [3:0]  dout_a1, dout_b1, dout_c1;
    logic        busy1, done1;

    int mode = 0;
    int errors = 0;
    int checks = 0;
    int relEdge = 0;
    int doneCount = 0;

    always #5 clk = ~clk;

    // External S-box stand-ins: 0 = identity, 1 = constant XOR, 2 = share-mixing rotate/XOR.
    function automatic logic [11:0] f1(input int m, input logic [11:0] x);
        case (m)
            1:       return x ^ 12'h111;
            2:       return {x[10:0], x[11]} ^ 12'h5A3;
            default: return x;
        endcase
    endfunction

    function automatic logic [11:0] f2(input int m, input logic [11:0] x);
        case (m)
            1:       return x ^ 12'h222;
            2:       return {x[2:0], x[11:3]} ^ 12'h96C;
            default: return x;
        endcase
    endfunction

    assign s1o16 = f1(mode, s1i16);
    assign s2o16 = f2(mode, s2i16);

    ti_sbox_sequencer #(.NIB(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16),
        .din_a(din_a16), .din_b(din_b16), .din_c(din_c16),
        .s1_in(s1i16), .s1_out(s1o16), .s2_in(s2i16), .s2_out(s2o16),
        .dout_a(dout_a16), .dout_b(dout_b16), .dout_c(dout_c16),
        .busy(busy16), .done(done16)
    );

    ti_sbox_sequencer #(.NIB(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .din_a(din_a1), .din_b(din_b1), .din_c(din_c1),
        .s1_in(s1i1), .s1_out(s1i1), .s2_in(s2i1), .s2_out(s2i1),
        .dout_a(dout_a1), .dout_b(dout_b1), .dout_c(dout_c1),
        .busy(busy1), .done(done1)
    );

    always @(posedge clk) begin
        #2;
        if (done16 === 1'b1) doneCount++;
    end

    // Expected share output: each nibble position passes independently through f2(f1(.)).
    function automatic logic [63:0] modelShare(input logic [63:0] a, b, c, input int share, input int m);
        logic [63:0] r;
        logic [11:0] p, q;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            p = {c[4*k +: 4], b[4*k +: 4], a[4*k +: 4]};
            q = f2(m, f1(m, p));
            r[4*k +: 4] = q[4*share +: 4];
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        relEdge++;
    endtask

    // Issues a start at the coming edge (edge 0); returns in the cycle after edge 0.
    task automatic applyStimulus(input logic [63:0] a, b, c);
        din_a16 = a;
        din_b16 = b;
        din_c16 = c;
        start16 = 1'b1;
        relEdge = -1;
        step();
        start16 = 1'b0;
    endtask

    task automatic waitDone(output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (done16 === 1'b1) begin
                at = relEdge;
                break;
            end
        end
    endtask

    task automatic checkShares(input string tag, input logic [63:0] a, b, c, input int m);
        checkOutput({tag, "_dout_a"}, dout_a16, modelShare(a, b, c, 0, m));
        checkOutput({tag, "_dout_b"}, dout_b16, modelShare(a, b, c, 1, m));
        checkOutput({tag, "_dout_c"}, dout_c16, modelShare(a, b, c, 2, m));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] a, b, c, a2, b2, c2;
        int at, cnt0, rel1;

        // Reset held with start asserted and random data: nothing may move.
        start16 = 1'b1;
        start1  = 1'b1;
        din_a16 = {$urandom(), $urandom()};
        din_b16 = {$urandom(), $urandom()};
        din_c16 = {$urandom(), $urandom()};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rst_busy", 64'(busy16), 64'h0);
            checkOutput("rst_done", 64'(done16), 64'h0);
            checkOutput("rst_dout_a", dout_a16, 64'h0);
            checkOutput("rst_s1_in", 64'(s1i16), 64'h0);
        end
        start16 = 1'b0;
        start1  = 1'b0;
        rst_n   = 1'b1;
        repeat (3) step();
        checkOutput("idle_busy", 64'(busy16), 64'h0);
        checkOutput("idle_s2_in", 64'(s2i16), 64'h0);

        // Identity stubs with ignored starts at edges 4 and 10, then a back-to-back start.
        mode = 0;
        a = 64'h0123456789ABCDEF;
        b = 64'h0;
        c = 64'h0;
        cnt0 = doneCount;
        applyStimulus(a, b, c);
        checkOutput("id_busy_c1", 64'(busy16), 64'h1);
        checkOutput("id_s1_in_c1", 64'(s1i16), 64'h00F);
        while (relEdge < 3) step();
        start16 = 1'b1;
        din_a16 = {$urandom(), $urandom()};
        step();
        start16 = 1'b0;
        while (relEdge < 9) step();
        start16 = 1'b1;
        din_b16 = {$urandom(), $urandom()};
        step();
        start16 = 1'b0;
        waitDone(at);
        checkOutput("id_done_edge", 64'(at), 64'd18);
        checkOutput("id_dout_a", dout_a16, 64'h0123456789ABCDEF);
        checkOutput("id_dout_b", dout_b16, 64'h0);
        checkOutput("id_dout_c", dout_c16, 64'h0);

        a2 = {$urandom(), $urandom()};
        b2 = {$urandom(), $urandom()};
        c2 = {$urandom(), $urandom()};
        applyStimulus(a2, b2, c2);
        checkOutput("b2b_done_low", 64'(done16), 64'h0);
        checkOutput("b2b_busy", 64'(busy16), 64'h1);
        waitDone(at);
        checkOutput("b2b_done_edge", 64'(at + 19), 64'd37);
        checkShares("b2b", a2, b2, c2, 0);
        checkOutput("b2b_done_count", 64'(doneCount - cnt0), 64'd2);

        // Constant-XOR stubs on an all-zero state.
        mode = 1;
        applyStimulus(64'h0, 64'h0, 64'h0);
        waitDone(at);
        checkOutput("xor_done_edge", 64'(at), 64'd18);
        checkOutput("xor_dout_a", dout_a16, 64'h3333333333333333);
        checkOutput("xor_dout_b", dout_b16, 64'h3333333333333333);
        checkOutput("xor_dout_c", dout_c16, 64'h3333333333333333);

        // Random states through share-mixing stubs.
        mode = 2;
        for (int n = 0; n < 4; n++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            c = {$urandom(), $urandom()};
            applyStimulus(a, b, c);
            waitDone(at);
            checkOutput("mix_done_edge", 64'(at), 64'd18);
            checkShares("mix", a, b, c, 2);
        end

        // Asynchronous reset between edges 5 and 6 aborts the operation.
        mode = 0;
        applyStimulus({$urandom(), $urandom()} | 64'h1, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        while (relEdge < 5) step();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy16), 64'h0);
        checkOutput("abort_dout_a", dout_a16, 64'h0);
        checkOutput("abort_dout_b", dout_b16, 64'h0);
        checkOutput("abort_s1_in", 64'(s1i16), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt0 = doneCount;
        repeat (25) step();
        checkOutput("abort_no_done", 64'(doneCount - cnt0), 64'd0);
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
        c = {$urandom(), $urandom()};
        applyStimulus(a, b, c);
        waitDone(at);
        checkOutput("post_abort_done_edge", 64'(at), 64'd18);
        checkShares("post_abort", a, b, c, 0);

        // NIB=1 boundary.
        for (int n = 0; n < 3; n++) begin
            din_a1 = (n == 0) ? 4'hA : 4'($urandom());
            din_b1 = (n == 0) ? 4'h0 : 4'($urandom());
            din_c1 = (n == 0) ? 4'h0 : 4'($urandom());
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            rel1 = -1;
            for (int i = 1; i < 12; i++) begin
                @(negedge clk);
                if (done1 === 1'b1) begin
                    rel1 = i;
                    break;
                end
            end
            checkOutput("nib1_done_edge", 64'(rel1), 64'd3);
            checkOutput("nib1_dout_a", 64'(dout_a1), 64'(din_a1));
            checkOutput("nib1_dout_b", 64'(dout_b1), 64'(din_b1));
            checkOutput("nib1_dout_c", 64'(dout_c1), 64'(din_c1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
